// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, issues single-outstanding imem reads, feeds decode
// through a 2-entry FIFO, and applies predictor next-PCs on B-type fetches.
//
// Ports:
//   CLK, nRST                   clock, synchronous active-low reset
//   imem_ren/addr/ihit/instr    instruction memory request/response
//   tbp_pc, tbp_enable_fetch    predictor lookup PC and valid-lookup strobe
//   tbp_nxt_pc, tbp_pred_*      predictor next PC and prediction bits
//   redirect_en, redirect_pc    mispredict flush from branch resolution
//   fd_valid/ready/instr/pc/
//   fd_pred_taken               fetch-to-decode FIFO head handshake
//   fetch_halted                fetch stopped on a halt word
//
// Build option: FETCH_GSHARE_EN selects tbp_pred_gshare as the prediction
// bit; otherwise tbp_pred_2bit is used.

module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  output logic        imem_ren,
  output logic [31:0] imem_addr,
  input  logic        imem_ihit,
  input  logic [31:0] imem_instr,
  output logic [31:0] tbp_pc,
  output logic        tbp_enable_fetch,
  input  logic [31:0] tbp_nxt_pc,
  input  logic        tbp_pred_2bit,
  input  logic        tbp_pred_gshare,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic        fd_valid,
  input  logic        fd_ready,
  output logic [31:0] fd_instr,
  output logic [31:0] fd_pc,
  output logic        fd_pred_taken,
  output logic        fetch_halted
);

  typedef enum logic [1:0] {
    RUN,
    WAIT,
    DISCARD,
    HALT
  } state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        pred;
  } fd_entry_t;

  localparam logic [1:0] DEPTH = FIFO_DEPTH[1:0];

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc_reg;
  logic [31:0] pc_nxt;
  logic [31:0] req_addr;
  logic [31:0] req_addr_nxt;

  fd_entry_t   fifo [FIFO_DEPTH];
  logic [1:0]  cnt;
  logic        head;
  logic        wr_idx;

  logic        issue;
  logic        ren_int;
  logic [31:0] addr_int;
  logic        accept;
  logic        is_br;
  logic        is_halt;
  logic        sel_pred;
  logic        pred_bit;
  logic        push;
  logic        pop;

`ifdef FETCH_GSHARE_EN
  logic unused_pred;
  assign sel_pred    = tbp_pred_gshare;
  assign unused_pred = tbp_pred_2bit;
`else
  logic unused_pred;
  assign sel_pred    = tbp_pred_2bit;
  assign unused_pred = tbp_pred_gshare;
`endif

  assign is_br   = imem_instr[6:0] == 7'b1100011;
  assign is_halt = imem_instr[6:0] == 7'b1111111;

  // A fresh request needs a free FIFO slot; with one request in
  // flight at most, that slot is still free when the response lands.
  assign issue   = (state == RUN) && (cnt != DEPTH) && !redirect_en;
  assign ren_int = issue || (state == WAIT) || (state == DISCARD);

  assign addr_int = (state == RUN) ? pc_reg : req_addr;

  // Responses in the redirect cycle belong to the wrong path.
  assign accept = imem_ihit && !redirect_en
               && (issue || (state == WAIT));

  assign pred_bit = is_br && sel_pred;
  assign push     = accept;
  assign pop      = (cnt != 2'd0) && fd_ready && !redirect_en;
  assign wr_idx   = head ^ cnt[0];

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc_reg;
    req_addr_nxt = req_addr;
    if (issue) begin
      req_addr_nxt = pc_reg;
    end
    if (redirect_en) begin
      pc_nxt = redirect_pc;
      // A request still in flight must be drained before refetching.
      if (((state == WAIT) || (state == DISCARD)) && !imem_ihit) begin
        state_nxt = DISCARD;
      end else begin
        state_nxt = RUN;
      end
    end else begin
      unique case (state)
        RUN, WAIT: begin
          if (accept) begin
            pc_nxt    = is_br ? tbp_nxt_pc : pc_reg + 32'd4;
            state_nxt = is_halt ? HALT : RUN;
          end else if (issue) begin
            state_nxt = WAIT;
          end
        end
        DISCARD: begin
          if (imem_ihit) begin
            state_nxt = RUN;
          end
        end
        HALT: begin
          state_nxt = HALT;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state    <= RUN;
      pc_reg   <= RESET_PC;
      req_addr <= RESET_PC;
      cnt      <= 2'd0;
      head     <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc_reg   <= pc_nxt;
      req_addr <= req_addr_nxt;
      if (redirect_en) begin
        cnt  <= 2'd0;
        head <= 1'b0;
      end else begin
        unique case ({push, pop})
          2'b10:   cnt <= cnt + 2'd1;
          2'b01:   cnt <= cnt - 2'd1;
          default: cnt <= cnt;
        endcase
        if (pop) begin
          head <= ~head;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      fifo[wr_idx] <= '{
        instr: imem_instr,
        pc:    addr_int,
        pred:  pred_bit
      };
    end
  end

  assign imem_ren  = nRST & ren_int;
  assign imem_addr = {32{nRST}} & addr_int;

  assign tbp_pc = {32{nRST}}
                & ((state == WAIT) ? req_addr : pc_reg);
  assign tbp_enable_fetch = nRST & accept & is_br;

  assign fd_valid      = nRST & (cnt != 2'd0);
  assign fd_instr      = {32{nRST}} & fifo[head].instr;
  assign fd_pc         = {32{nRST}} & fifo[head].pc;
  assign fd_pred_taken = nRST & fifo[head].pred;
  assign fetch_halted  = nRST & (state == HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios plus a randomized run checked against
// a transaction-level model of fetch (outstanding flag, PC, FIFO queue).

module tb_fetch_stage;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        imem_ren;
  logic [31:0] imem_addr;
  logic        imem_ihit;
  logic [31:0] imem_instr;
  logic [31:0] tbp_pc;
  logic        tbp_enable_fetch;
  logic [31:0] tbp_nxt_pc;
  logic        tbp_pred_2bit;
  logic        tbp_pred_gshare;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        fd_valid;
  logic        fd_ready;
  logic [31:0] fd_instr;
  logic [31:0] fd_pc;
  logic        fd_pred_taken;
  logic        fetch_halted;

  int checks = 0;
  int errors = 0;

`ifdef FETCH_GSHARE_EN
  localparam bit GS = 1'b1;
`else
  localparam bit GS = 1'b0;
`endif

  localparam logic [31:0] I0  = 32'h0000_0013;
  localparam logic [31:0] I1  = 32'h0010_0093;
  localparam logic [31:0] I2  = 32'h0020_0113;
  localparam logic [31:0] BR  = 32'h0020_8463;
  localparam logic [31:0] HLT = 32'hFFFF_FFFF;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        pred;
  } ent_t;

  fetch_stage #(.RESET_PC(32'h200)) dut (
    .CLK(CLK), .nRST(nRST),
    .imem_ren(imem_ren), .imem_addr(imem_addr),
    .imem_ihit(imem_ihit), .imem_instr(imem_instr),
    .tbp_pc(tbp_pc), .tbp_enable_fetch(tbp_enable_fetch),
    .tbp_nxt_pc(tbp_nxt_pc), .tbp_pred_2bit(tbp_pred_2bit),
    .tbp_pred_gshare(tbp_pred_gshare),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .fd_valid(fd_valid), .fd_ready(fd_ready),
    .fd_instr(fd_instr), .fd_pc(fd_pc),
    .fd_pred_taken(fd_pred_taken), .fetch_halted(fetch_halted)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    imem_ihit = 0; imem_instr = I0; redirect_en = 0;
    redirect_pc = 0; fd_ready = 0; tbp_nxt_pc = 0;
    tbp_pred_2bit = 0; tbp_pred_gshare = 0;
  endtask

  // Redirect with a same-cycle hit always lands in RUN with an empty FIFO.
  task automatic flush(input logic [31:0] pc);
    idle();
    redirect_en = 1; redirect_pc = pc; imem_ihit = 1;
    tick();
    idle();
  endtask

  task automatic test_reset();
    idle();
    nRST = 0; imem_ihit = 1; imem_instr = BR; fd_ready = 1;
    tick(); tick();
    #2;
    checks++; if (imem_ren !== 1'b0) begin errors++;
      $display("FAIL rst_ren got %b exp 0", imem_ren); end
    checks++; if (imem_addr !== 32'h0) begin errors++;
      $display("FAIL rst_addr got %h exp 0", imem_addr); end
    checks++; if ({fd_valid, tbp_enable_fetch, fetch_halted} !== 3'b000) begin
      errors++; $display("FAIL rst_flags got %b exp 000",
        {fd_valid, tbp_enable_fetch, fetch_halted}); end
    checks++; if (tbp_pc !== 32'h0) begin errors++;
      $display("FAIL rst_tbp_pc got %h exp 0", tbp_pc); end
    tick();
    idle();
    nRST = 1;
  endtask

  task automatic test_zero_wait();
    imem_ihit = 1; imem_instr = I1;
    #2;
    checks++; if (imem_ren !== 1'b1 || imem_addr !== 32'h200) begin errors++;
      $display("FAIL zw_req got %b/%h exp 1/200", imem_ren, imem_addr); end
    checks++; if (tbp_pc !== 32'h200 || tbp_enable_fetch !== 1'b0) begin errors++;
      $display("FAIL zw_tbp got %h/%b exp 200/0", tbp_pc, tbp_enable_fetch); end
    tick();
    imem_ihit = 0;
    #2;
    checks++; if (fd_valid !== 1'b1 || fd_pc !== 32'h200 || fd_instr !== I1) begin
      errors++; $display("FAIL zw_push got %b/%h/%h exp 1/200/%h",
        fd_valid, fd_pc, fd_instr, I1); end
    checks++; if (imem_addr !== 32'h204) begin errors++;
      $display("FAIL zw_next got %h exp 204", imem_addr); end
    tick();
  endtask

  task automatic test_branch();
    flush(32'h100);
    imem_ihit = 1; imem_instr = BR; tbp_nxt_pc = 32'h108;
    tbp_pred_2bit = 1; tbp_pred_gshare = 0;
    #2;
    checks++; if (tbp_enable_fetch !== 1'b1 || imem_addr !== 32'h100) begin
      errors++; $display("FAIL br_lookup got %b/%h exp 1/100",
        tbp_enable_fetch, imem_addr); end
    tick();
    idle();
    #2;
    checks++; if (imem_addr !== 32'h108) begin errors++;
      $display("FAIL br_target got %h exp 108", imem_addr); end
    checks++; if (fd_pred_taken !== !GS || fd_pc !== 32'h100) begin errors++;
      $display("FAIL br_pred got %b/%h exp %b/100", fd_pred_taken, fd_pc, !GS); end
    tick();
  endtask

  task automatic test_fifo_full();
    flush(32'h0);
    imem_ihit = 1; imem_instr = I0;
    #2;
    checks++; if (imem_addr !== 32'h0) begin errors++;
      $display("FAIL ff_a0 got %h exp 0", imem_addr); end
    tick();
    imem_instr = I1;
    #2;
    checks++; if (imem_ren !== 1'b1 || imem_addr !== 32'h4) begin errors++;
      $display("FAIL ff_a1 got %b/%h exp 1/4", imem_ren, imem_addr); end
    tick();
    imem_instr = I2;
    #2;
    checks++; if (imem_ren !== 1'b0) begin errors++;
      $display("FAIL ff_credit got %b exp 0", imem_ren); end
    tick();
    imem_ihit = 0; fd_ready = 1;
    #2;
    checks++; if (fd_pc !== 32'h0 || fd_instr !== I0 || imem_ren !== 1'b0) begin
      errors++; $display("FAIL ff_head0 got %h/%h/%b exp 0/%h/0",
        fd_pc, fd_instr, imem_ren, I0); end
    tick();
    imem_ihit = 1; imem_instr = I2;
    #2;
    checks++; if (fd_pc !== 32'h4 || fd_instr !== I1) begin errors++;
      $display("FAIL ff_head1 got %h/%h exp 4/%h", fd_pc, fd_instr, I1); end
    checks++; if (imem_ren !== 1'b1 || imem_addr !== 32'h8) begin errors++;
      $display("FAIL ff_resume got %b/%h exp 1/8", imem_ren, imem_addr); end
    tick();
    idle();
    #2;
    checks++; if (fd_valid !== 1'b1 || fd_pc !== 32'h8 || fd_instr !== I2
                  || imem_addr !== 32'hC) begin
      errors++; $display("FAIL ff_pushpop got %b/%h/%h/%h exp 1/8/%h/c",
        fd_valid, fd_pc, fd_instr, imem_addr, I2); end
    tick();
  endtask

  task automatic test_redirect_wait();
    flush(32'h40);
    tick();
    #2;
    checks++; if (imem_ren !== 1'b1 || imem_addr !== 32'h40) begin errors++;
      $display("FAIL rw_wait got %b/%h exp 1/40", imem_ren, imem_addr); end
    tick();
    redirect_en = 1; redirect_pc = 32'h400;
    #2;
    checks++; if (imem_ren !== 1'b1 || imem_addr !== 32'h40) begin errors++;
      $display("FAIL rw_redir got %b/%h exp 1/40", imem_ren, imem_addr); end
    tick();
    idle();
    #2;
    checks++; if (imem_ren !== 1'b1 || imem_addr !== 32'h40) begin errors++;
      $display("FAIL rw_discard got %b/%h exp 1/40", imem_ren, imem_addr); end
    tick();
    imem_ihit = 1; imem_instr = BR;
    #2;
    checks++; if (tbp_enable_fetch !== 1'b0) begin errors++;
      $display("FAIL rw_drop got %b exp 0", tbp_enable_fetch); end
    tick();
    idle();
    #2;
    checks++; if (fd_valid !== 1'b0 || imem_ren !== 1'b1
                  || imem_addr !== 32'h400) begin
      errors++; $display("FAIL rw_refetch got %b/%b/%h exp 0/1/400",
        fd_valid, imem_ren, imem_addr); end
    tick();
  endtask

  task automatic test_redirect_hit();
    flush(32'h10);
    imem_ihit = 1; imem_instr = I0;
    tick();
    redirect_en = 1; redirect_pc = 32'h300; imem_instr = BR; fd_ready = 1;
    #2;
    checks++; if (tbp_enable_fetch !== 1'b0 || imem_ren !== 1'b0) begin errors++;
      $display("FAIL rh_cycle got %b/%b exp 0/0", tbp_enable_fetch, imem_ren); end
    tick();
    idle();
    #2;
    checks++; if (fd_valid !== 1'b0 || imem_addr !== 32'h300) begin errors++;
      $display("FAIL rh_after got %b/%h exp 0/300", fd_valid, imem_addr); end
    tick();
  endtask

  task automatic test_halt();
    flush(32'h20);
    imem_ihit = 1; imem_instr = HLT;
    tick();
    idle();
    #2;
    checks++; if (fetch_halted !== 1'b1 || imem_ren !== 1'b0) begin errors++;
      $display("FAIL ht_state got %b/%b exp 1/0", fetch_halted, imem_ren); end
    checks++; if (fd_valid !== 1'b1 || fd_instr !== HLT || fd_pc !== 32'h20) begin
      errors++; $display("FAIL ht_push got %b/%h/%h exp 1/ffffffff/20",
        fd_valid, fd_instr, fd_pc); end
    tick();
    imem_ihit = 1;
    #2;
    checks++; if (imem_ren !== 1'b0) begin errors++;
      $display("FAIL ht_noreq got %b exp 0", imem_ren); end
    tick();
    idle();
    redirect_en = 1; redirect_pc = 32'h80;
    tick();
    idle();
    #2;
    checks++; if (fetch_halted !== 1'b0 || imem_ren !== 1'b1
                  || imem_addr !== 32'h80 || fd_valid !== 1'b0) begin
      errors++; $display("FAIL ht_resume got %b/%b/%h/%b exp 0/1/80/0",
        fetch_halted, imem_ren, imem_addr, fd_valid); end
    tick();
  endtask

  task automatic test_wrap();
    flush(32'hFFFF_FFFC);
    imem_ihit = 1; imem_instr = I0;
    tick();
    idle();
    #2;
    checks++; if (imem_addr !== 32'h0) begin errors++;
      $display("FAIL wrap got %h exp 0", imem_addr); end
    tick();
  endtask

  task automatic test_random();
    ent_t        q[$];
    ent_t        e;
    logic [31:0] m_pc, out_addr, exp_addr, r;
    bit          outst, stale, halted, exp_ren, acc, br;
    int          sel;
    flush(32'h1000);
    m_pc = 32'h1000; out_addr = 0; outst = 0; stale = 0; halted = 0;
    for (int i = 0; i < 1500; i++) begin
      redirect_en = ($urandom_range(0, 24) == 0);
      redirect_pc = $urandom() & 32'h0000_0FFC;
      imem_ihit = ($urandom_range(0, 9) < 6);
      fd_ready = ($urandom_range(0, 3) != 0);
      r = $urandom();
      sel = $urandom_range(0, 99);
      if (sel < 30)      imem_instr = {r[31:7], 7'b1100011};
      else if (sel < 33) imem_instr = {r[31:7], 7'b1111111};
      else               imem_instr = {r[31:7], 7'b0010011};
      tbp_nxt_pc = $urandom() & 32'h0000_3FFC;
      tbp_pred_2bit = 1'($urandom());
      tbp_pred_gshare = 1'($urandom());
      #2;
      exp_ren = !halted && (outst || (q.size() < 2 && !redirect_en));
      exp_addr = outst ? out_addr : m_pc;
      br = imem_instr[6:0] == 7'b1100011;
      acc = exp_ren && imem_ihit && !redirect_en && !stale;
      checks++; if (imem_ren !== exp_ren) begin errors++;
        $display("FAIL rnd_ren cyc %0d got %b exp %b", i, imem_ren, exp_ren); end
      if (exp_ren) begin
        checks++; if (imem_addr !== exp_addr) begin errors++;
          $display("FAIL rnd_addr cyc %0d got %h exp %h", i, imem_addr, exp_addr);
        end
      end
      checks++; if (fd_valid !== (q.size() != 0)) begin errors++;
        $display("FAIL rnd_valid cyc %0d got %b exp %b", i, fd_valid, q.size() != 0);
      end
      if (q.size() != 0) begin
        checks++;
        if (fd_instr !== q[0].instr || fd_pc !== q[0].pc
            || fd_pred_taken !== q[0].pred) begin
          errors++; $display("FAIL rnd_head cyc %0d got %h/%h/%b exp %h/%h/%b",
            i, fd_instr, fd_pc, fd_pred_taken, q[0].instr, q[0].pc, q[0].pred);
        end
      end
      checks++; if (tbp_enable_fetch !== (acc && br)) begin errors++;
        $display("FAIL rnd_tbp_en cyc %0d got %b exp %b", i, tbp_enable_fetch,
          acc && br); end
      checks++; if (fetch_halted !== halted) begin errors++;
        $display("FAIL rnd_halt cyc %0d got %b exp %b", i, fetch_halted, halted); end
      if (redirect_en) begin
        q.delete();
        m_pc = redirect_pc;
        halted = 0;
        if (outst && !imem_ihit) stale = 1;
        else begin outst = 0; stale = 0; end
      end else begin
        if (q.size() != 0 && fd_ready) void'(q.pop_front());
        if (exp_ren && imem_ihit) begin
          if (!stale) begin
            e.instr = imem_instr; e.pc = exp_addr;
            e.pred = br && (GS ? tbp_pred_gshare : tbp_pred_2bit);
            q.push_back(e);
            m_pc = br ? tbp_nxt_pc : exp_addr + 32'd4;
            halted = imem_instr[6:0] == 7'b1111111;
          end
          outst = 0; stale = 0;
        end else if (exp_ren) begin
          outst = 1; out_addr = exp_addr;
        end
      end
      tick();
    end
    idle();
  endtask

  task automatic test_reset_midflight();
    flush(32'h500);
    tick();
    nRST = 0;
    #2;
    checks++; if (imem_ren !== 1'b0 || imem_addr !== 32'h0) begin errors++;
      $display("FAIL rm_hold got %b/%h exp 0/0", imem_ren, imem_addr); end
    tick();
    nRST = 1;
    #2;
    checks++; if (imem_ren !== 1'b1 || imem_addr !== 32'h200
                  || fd_valid !== 1'b0) begin
      errors++; $display("FAIL rm_restart got %b/%h/%b exp 1/200/0",
        imem_ren, imem_addr, fd_valid); end
    tick();
  endtask

  initial begin
    nRST = 0;
    idle();
    tick();
    test_reset();
    test_zero_wait();
    test_branch();
    test_fifo_full();
    test_redirect_wait();
    test_redirect_hit();
    test_halt();
    test_wrap();
    test_random();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage that owns the PC and issues single-outstanding requests to instruction memory.
- Queries the branch predictor with the current PC and applies its next-PC on fetched B-type instructions.
- Passes {instr, pc, prediction} to decode through a 2-entry FIFO with valid/ready.
- Sits directly upstream of decode and beside the branch predictor; also accepts mispredict redirects from branch resolution.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- FIFO_DEPTH, 2, fetch-to-decode buffer entries; only 2 is supported.

Ports:
- CLK  input  1  clock
- nRST  input  1  synchronous active-low reset
- imem_ren  output  1  instruction read request; held until imem_ihit
- imem_addr  output  32  request address; stable while a request is outstanding
- imem_ihit  input  1  response valid this cycle
- imem_instr  input  32  instruction data, valid with imem_ihit
- tbp_pc  output  32  current PC presented to the predictor (= pc_reg)
- tbp_enable_fetch  output  1  fetched instruction is B-type; predictor lookup is valid
- tbp_nxt_pc  input  32  predicted next PC, combinational from the predictor
- tbp_pred_2bit  input  1  2-bit counter prediction
- tbp_pred_gshare  input  1  gshare prediction
- redirect_en  input  1  mispredict flush from branch resolution
- redirect_pc  input  32  correct PC
- fd_valid  output  1  FIFO head valid
- fd_ready  input  1  decode accepts the head
- fd_instr  output  32  head instruction
- fd_pc  output  32  head PC
- fd_pred_taken  output  1  head prediction bit
- fetch_halted  output  1  state == HALT

Behaviour:
- Reset, while nRST is low at a clock edge:
  - pc_reg = RESET_PC, req_addr = RESET_PC, state = RUN, FIFO count = 0.
  - All outputs are combinationally forced low while nRST is low.
  - A reset during an outstanding request abandons it; imem tolerates imem_ren dropping.
- States: RUN, WAIT, DISCARD, HALT.
- imem_ren = (RUN && cnt < 2 && !redirect_en) || WAIT || DISCARD.
- imem_addr = pc_reg in RUN, otherwise req_addr. req_addr latches pc_reg when a RUN request is issued.
- Zero-wait hit: imem_ihit may arrive in the same cycle as the request.
- Accept condition: imem_ihit in RUN with ren high, or imem_ihit in WAIT. On accept:
  - Push {imem_instr, issuing pc, pred} into the FIFO.
  - is_br = (imem_instr[6:0] == 7'b1100011). tbp_enable_fetch = accept && is_br.
  - Next PC: pc_reg <= is_br ? tbp_nxt_pc : pc_reg + 4. Addition wraps mod 2^32.
  - pred = is_br ? selected predictor bit : 0.
  - Next state: RUN, or HALT if imem_instr[6:0] == 7'b1111111 (the halt itself is pushed).
- RUN, ren high, no ihit -> WAIT.
- WAIT: hold the request until ihit.
- Credit rule: issue only when cnt < 2. Since at most one request is outstanding, a push never overflows. Push and pop in the same cycle leaves cnt unchanged.
- Pop when fd_valid && fd_ready. FIFO is first-in first-out. fd_* show the head entry; fd_valid = cnt != 0.
- redirect_en has highest priority over everything:
  - FIFO is cleared (cnt = 0); any same-cycle pop is ignored.
  - pc_reg <= redirect_pc.
  - Any ihit in the same cycle is dropped.
  - Next state:
    - Request outstanding and no ihit this cycle (WAIT, or RUN with a request that started earlier): -> DISCARD.
    - Otherwise (RUN, ihit in the same cycle, HALT): -> RUN.
  - No new request is issued in the redirect cycle.
- DISCARD: the response is dropped on ihit -> RUN. A new redirect in DISCARD updates pc_reg and stays in DISCARD.
- HALT: no requests; only redirect_en leaves HALT (-> RUN).
- tbp_pc = pc_reg in RUN; req_addr in WAIT.

Optional Feature:
- FETCH_GSHARE_EN defined: the prediction bit is tbp_pred_gshare.
- Not defined: the prediction bit is tbp_pred_2bit. tbp_pred_gshare is ignored.
- Port list is identical in both builds.

Test Plan:
- Reset with RESET_PC=32'h200; release; imem_ihit same cycle with ADDI -> imem_addr=0x200, FIFO entry pc=0x200; next imem_addr=0x204.
- B-type 32'h00208463 at 0x100, tbp_nxt_pc=0x108, tbp_pred_2bit=1, tbp_pred_gshare=0 -> next fetch at 0x108. fd_pred_taken=1 without the macro, 0 with it.
- fd_ready=0, 1-cycle hits -> exactly 2 entries accepted, imem_ren low, order preserved; fd_ready=1 -> pops 0x0, 0x4 in order, fetch resumes at 0x8.
- 3-cycle miss pending in WAIT; redirect_en with redirect_pc=0x400 -> DISCARD, imem_addr unchanged, response dropped, next request to 0x400; FIFO empty.
- redirect_en in the same cycle as imem_ihit and fd_ready=1 -> no push, cnt=0, next request to redirect_pc.
- Fetch halt word 32'hFFFF_FFFF -> pushed, fetch_halted=1, no further imem_ren; redirect_en to 0x80 -> RUN, fetch at 0x80.
